// File: rtl/regfile_write_arbiter.sv
// Two-requester write-port arbiter for RegisterFile with round-robin grants
// and a clear sweep that zeroes every register after reset or on request.
module regfile_write_arbiter #(
  parameter int N = 8,
  parameter int A = 3,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [A-1:0] a_addr,
  input  logic [N-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [A-1:0] b_addr,
  input  logic [N-1:0] b_data,
  output logic         b_ready,
  input  logic         clr_start,
  output logic         busy,
  output logic [1:0]   gnt,
  output logic         we3,
  output logic [A-1:0] wa3,
  output logic [N-1:0] wd3
);

  typedef enum logic {CLEAR, SERVE} state_t;

  typedef struct packed {
    logic         full;
    logic [A-1:0] addr;
    logic [N-1:0] data;
  } slot_t;

  state_t       state, state_n;
  slot_t        sa, sa_n, sb, sb_n;
  logic         ptr, ptr_n;
  logic [A-1:0] cnt, cnt_n;
  logic         we3_n;
  logic [A-1:0] wa3_n;
  logic [N-1:0] wd3_n;
  logic [1:0]   gnt_n;
  logic         ga, gb;

  assign busy    = (state == CLEAR);
  assign a_ready = rst & (state == SERVE) & ~sa.full;
  assign b_ready = rst & (state == SERVE) & ~sb.full;

  // ptr=0 favours A when both slots hold a request
  assign ga = sa.full & (~sb.full | ~ptr);
  assign gb = sb.full & ~ga;

  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    ptr_n   = ptr;
    cnt_n   = cnt;
    we3_n   = 1'b0;
    wa3_n   = wa3;
    wd3_n   = wd3;
    gnt_n   = 2'b00;
    unique case (state)
      CLEAR: begin
        we3_n = 1'b1;
        wa3_n = cnt;
        wd3_n = '0;
        cnt_n = cnt + 1'b1;
        if (cnt == {A{1'b1}})
          state_n = SERVE;
      end
      SERVE: begin
        if (clr_start) begin
          sa_n.full = 1'b0;
          sb_n.full = 1'b0;
          cnt_n     = '0;
          state_n   = CLEAR;
        end else begin
          if (a_valid && a_ready)
            sa_n = '{full: 1'b1, addr: a_addr, data: a_data};
          if (b_valid && b_ready)
            sb_n = '{full: 1'b1, addr: b_addr, data: b_data};
          unique case (1'b1)
            ga: begin
              we3_n     = 1'b1;
              wa3_n     = sa.addr;
              wd3_n     = sa.data;
              gnt_n     = 2'b01;
              sa_n.full = 1'b0;
              ptr_n     = 1'b1;
            end
            gb: begin
              we3_n     = 1'b1;
              wa3_n     = sb.addr;
              wd3_n     = sb.data;
              gnt_n     = 2'b10;
              sb_n.full = 1'b0;
              ptr_n     = 1'b0;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : SERVE;
      sa    <= '0;
      sb    <= '0;
      ptr   <= 1'b0;
      cnt   <= '0;
      we3   <= 1'b0;
      wa3   <= '0;
      wd3   <= '0;
      gnt   <= 2'b00;
    end else begin
      state <= state_n;
      sa    <= sa_n;
      sb    <= sb_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      we3   <= we3_n;
      wa3   <= wa3_n;
      wd3   <= wd3_n;
      gnt   <= gnt_n;
    end
  end

endmodule
